// File: rtl/mul_acc_pkg.sv
// Shared definitions for the multiply-accumulate stage: FSM states and default sizes.
`timescale 1ns/1ps
package mul_acc_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 2;
  localparam int unsigned ACC_W_DEF         = 72;
  localparam int unsigned PROD_W            = 64;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/mul_acc_stage_mul.sv
// Combinational 32x32 unsigned multiplier built from four 16x16 partial products.
`timescale 1ns/1ps
module Mul_32_Hybrid_64_BK1_SA5 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] out
);

  logic [31:0] pp_ll;
  logic [31:0] pp_lh;
  logic [31:0] pp_hl;
  logic [31:0] pp_hh;

  assign pp_ll = 32'(a[15:0]) * 32'(b[15:0]);
  assign pp_lh = 32'(a[15:0]) * 32'(b[31:16]);
  assign pp_hl = 32'(a[31:16]) * 32'(b[15:0]);
  assign pp_hh = 32'(a[31:16]) * 32'(b[31:16]);

  // Cross terms carry weight 2^16; the total never exceeds 64 bits.
  assign out = {pp_hh, pp_ll}
             + ({32'd0, pp_lh} << 16)
             + ({32'd0, pp_hl} << 16);

endmodule

// File: rtl/mul_acc_stage.sv
// Multiply-accumulate stage: accepts 32x32 operand beats, lets the product settle
// for SETTLE_CYCLES cycles, then loads or adds it into a wide accumulator.
`timescale 1ns/1ps
module mul_acc_stage
  import mul_acc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned ACC_W         = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("mul_acc_stage: SETTLE_CYCLES must be 1..15");
  end
  if (ACC_W < 64 || ACC_W > 96) begin : g_bad_acc_w
    $error("mul_acc_stage: ACC_W must be 64..96");
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               rdy_q;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum;
  logic               accept;

  // prod is a SETTLE_CYCLES multicycle path from op_a_q/op_b_q to acc_q/ovf_q;
  // the operand registers are held for the whole settle window.
  Mul_32_Hybrid_64_BK1_SA5 u_mul (
    .a   (op_a_q),
    .b   (op_b_q),
    .out (prod)
  );

  // rdy_q keeps in_ready low until the first edge after reset is released.
  assign in_ready  = rdy_q & (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    first_d = first_q;
    last_d  = last_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, acc_q} + (ACC_W+1)'(prod);

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          first_d = in_first;
          last_d  = in_last;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (first_q) begin
            acc_d = ACC_W'(prod);
            ovf_d = 1'b0;
          end else begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
          end
          state_d = last_q ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      first_q <= first_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_acc_stage.sv
// Self-checking bench for mul_acc_stage: directed scenarios plus randomized beats
// against an arithmetic reference of the accumulator at widths 72 and 64.
`timescale 1ns/1ps
module tb_mul_acc_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic        in_ready, out_valid, busy, out_ovf;
  logic [71:0] out_acc;
  logic        in_ready64, out_valid64, busy64, out_ovf64;
  logic [63:0] out_acc64;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] m_acc72, m_acc64;
  logic         m_ovf72, m_ovf64;
  localparam logic [127:0] LIM72 = 128'd1 << 72;
  localparam logic [127:0] LIM64 = 128'd1 << 64;

  always #5 clk = ~clk;

  mul_acc_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  mul_acc_stage #(.SETTLE_CYCLES(2), .ACC_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid64), .out_ready(out_ready), .out_acc(out_acc64),
    .out_ovf(out_ovf64), .busy(busy64)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_acc72 = '0; m_acc64 = '0; m_ovf72 = 1'b0; m_ovf64 = 1'b0;
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input logic f);
    logic [127:0] p, s;
    p = 128'(a) * 128'(b);
    if (f) begin
      m_acc72 = p; m_acc64 = p; m_ovf72 = 1'b0; m_ovf64 = 1'b0;
    end else begin
      s = m_acc72 + p;
      if (s >= LIM72) begin s = s - LIM72; m_ovf72 = 1'b1; end
      m_acc72 = s;
      s = m_acc64 + p;
      if (s >= LIM64) begin s = s - LIM64; m_ovf64 = 1'b1; end
      m_acc64 = s;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(a, b, f);
    #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    in_first = 1'($urandom); in_last = 1'($urandom);
  endtask

  task automatic get_result(input int stall, output logic [71:0] a72, output logic o72,
                            output logic [63:0] a64, output logic o64);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin
      n_err++;
      $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, n);
    end
    repeat (stall) @(negedge clk);
    a72 = out_acc; o72 = out_ovf; a64 = out_acc64; o64 = out_ovf64;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_valid64 !== 1'b0) begin n_err++;
      $display("FAIL rst_out_valid: got %0b/%0b required 0", out_valid, out_valid64); end
    n_vec++; if (busy !== 1'b0 || busy64 !== 1'b0) begin n_err++;
      $display("FAIL rst_busy: got %0b/%0b required 0", busy, busy64); end
    n_vec++; if (in_ready !== 1'b0 || in_ready64 !== 1'b0) begin n_err++;
      $display("FAIL rst_in_ready: got %0b/%0b required 0", in_ready, in_ready64); end
    n_vec++; if (out_acc !== 72'd0 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL rst_acc: got %0h/%0b required 0/0", out_acc, out_ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL rst_release_ready_early: got %0b required 0", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1 || in_ready64 !== 1'b1) begin n_err++;
      $display("FAIL rst_release_ready: got %0b/%0b required 1", in_ready, in_ready64); end
  endtask

  task automatic test_single();
    send_beat(32'd3, 32'd5, 1'b1, 1'b1);
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL single_k+1: busy=%0b in_ready=%0b out_valid=%0b required 1/0/0",
               busy, in_ready, out_valid); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL single_early_valid: got %0b required 0", out_valid); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_acc !== 72'd15 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL single_result: valid=%0b acc=%0d ovf=%0b required 1/15/0",
               out_valid, out_acc, out_ovf); end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL single_release: valid=%0b in_ready=%0b required 0/1", out_valid, in_ready); end
  endtask

  task automatic test_chain();
    logic [31:0] av [3] = '{32'd2, 32'd4, 32'd6};
    logic [31:0] bv [3] = '{32'd3, 32'd5, 32'd7};
    logic [71:0] r72; logic r_o72; logic [63:0] r64; logic r_o64;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_beat(av[i], bv[i], 1'(i == 0), 1'b0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_vec++; if (in_ready !== 1'(c == 2)) begin n_err++;
          $display("FAIL chain_ready beat%0d cyc%0d: got %0b required %0b",
                   i, c, in_ready, 1'(c == 2)); end
      end
    end
    send_beat(av[2], bv[2], 1'b0, 1'b1);
    get_result(0, r72, r_o72, r64, r_o64);
    n_vec++; if (r72 !== 72'd68 || r_o72 !== 1'b0) begin n_err++;
      $display("FAIL chain_result: got %0d ovf=%0b required 68/0", r72, r_o72); end
  endtask

  task automatic test_hold_stall();
    int n = 0;
    logic [71:0] r72; logic r_o72; logic [63:0] r64; logic r_o64;
    send_beat(32'd7, 32'd8, 1'b1, 1'b1);
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    in_a = 32'd1; in_b = 32'd1; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 72'd56) begin n_err++;
        $display("FAIL hold_stall cyc%0d: valid=%0b in_ready=%0b acc=%0d required 1/0/56",
                 c, out_valid, in_ready, out_acc); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL hold_no_early_accept: busy=%0b valid=%0b required 0/0", busy, out_valid); end
    @(posedge clk);
    model_beat(32'd1, 32'd1, 1'b1);
    #1 in_valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL hold_accept_after: busy=%0b required 1", busy); end
    get_result(0, r72, r_o72, r64, r_o64);
    n_vec++; if (r72 !== 72'd1) begin n_err++;
      $display("FAIL hold_next_result: got %0d required 1", r72); end
  endtask

  task automatic test_reset_abort();
    logic [71:0] r72; logic r_o72; logic [63:0] r64; logic r_o64;
    send_beat(32'd9, 32'd9, 1'b1, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_acc !== 72'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_immediate: valid=%0b acc=%0d busy=%0b in_ready=%0b required 0/0/0/0",
               out_valid, out_acc, busy, in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || out_acc !== 72'd0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL abort_discard: valid=%0b acc=%0d in_ready=%0b required 0/0/1",
               out_valid, out_acc, in_ready); end
    send_beat(32'd1, 32'd2, 1'b1, 1'b1);
    get_result(0, r72, r_o72, r64, r_o64);
    n_vec++; if (r72 !== 72'd2 || r_o72 !== 1'b0) begin n_err++;
      $display("FAIL abort_next_result: got %0d ovf=%0b required 2/0", r72, r_o72); end
  endtask

  task automatic test_wrap();
    logic [71:0] r72; logic r_o72; logic [63:0] r64; logic r_o64;
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    get_result(1, r72, r_o72, r64, r_o64);
    n_vec++; if (r64 !== 64'hFFFF_FFFC_0000_0002 || r_o64 !== 1'b1) begin n_err++;
      $display("FAIL wrap64: got %0h ovf=%0b required fffffffc00000002/1", r64, r_o64); end
    n_vec++; if (r72 !== 72'h1_FFFF_FFFC_0000_0002 || r_o72 !== 1'b0) begin n_err++;
      $display("FAIL wrap72: got %0h ovf=%0b required 1fffffffc00000002/0", r72, r_o72); end
    send_beat(32'd1, 32'd1, 1'b1, 1'b1);
    get_result(0, r72, r_o72, r64, r_o64);
    n_vec++; if (r64 !== 64'd1 || r_o64 !== 1'b0) begin n_err++;
      $display("FAIL wrap_clear: got %0h ovf=%0b required 1/0", r64, r_o64); end
    send_beat(32'd10, 32'd10, 1'b0, 1'b1);
    get_result(0, r72, r_o72, r64, r_o64);
    n_vec++; if (r72 !== 72'd101 || r64 !== 64'd101) begin n_err++;
      $display("FAIL retained_acc: got %0d/%0d required 101", r72, r64); end
  endtask

  task automatic test_random();
    logic [71:0] r72; logic r_o72; logic [63:0] r64; logic r_o64;
    logic [31:0] a, b;
    logic f, l;
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      f = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send_beat(a, b, f, l);
      if (l) begin
        get_result($urandom_range(0, 3), r72, r_o72, r64, r_o64);
        n_vec++;
        if (r72 !== m_acc72[71:0] || r_o72 !== m_ovf72 ||
            r64 !== m_acc64[63:0] || r_o64 !== m_ovf64) begin
          n_err++;
          $display("FAIL random beat%0d: got %0h/%0b %0h/%0b required %0h/%0b %0h/%0b",
                   i, r72, r_o72, r64, r_o64, m_acc72[71:0], m_ovf72, m_acc64[63:0], m_ovf64);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_chain();
    test_hold_stall();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_acc_stage.md
MUL_ACC_STAGE -- requirements
Module: mul_acc_stage

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the cycles allowed for the combinational multiplier to settle; legal range 1..15.
REQ-002 SHALL have parameter ACC_W, default 72, giving the accumulator width; legal range 64..96.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  stage can accept a beat.
REQ-008 in_a  input  32  unsigned multiplicand.
REQ-009 in_b  input  32  unsigned multiplier.
REQ-010 in_first  input  1  beat starts a new accumulation: load the product, do not add it.
REQ-011 in_last  input  1  beat ends the accumulation: present the result.
REQ-012 out_valid  output  1  accumulated result available.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_acc  output  ACC_W  accumulated sum of products.
REQ-015 out_ovf  output  1  sticky flag: the accumulation wrapped.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, SETTLE and HOLD.
REQ-018 IDLE: in_ready=1; a beat is accepted when in_valid & in_ready at a rising edge.
REQ-019 On acceptance, SHALL register a, b, first and last, load settle_cnt=SETTLE_CYCLES-1, and move to SETTLE.
REQ-020 SETTLE: in_ready=0, and the registered a and b SHALL stay stable at the multiplier inputs.
REQ-021 SETTLE: while settle_cnt!=0, SHALL decrement settle_cnt.
REQ-022 SETTLE: at the edge where settle_cnt==0, SHALL sample the 64-bit product and update the accumulator.
REQ-023 Accumulator update when first=1: acc <= zero-extended product and ovf <= 0.
REQ-024 Accumulator update when first=0: acc <= (acc + product) mod 2^ACC_W, and ovf <= ovf | carry-out of bit ACC_W-1.
REQ-025 After the update, SHALL go to HOLD if last=1, otherwise to IDLE.
REQ-026 Timing: for a beat accepted at edge k, acc SHALL update at edge k+SETTLE_CYCLES.
REQ-027 Timing: out_valid SHALL rise at edge k+SETTLE_CYCLES when last=1.
REQ-028 Throughput SHALL be one beat per SETTLE_CYCLES+1 cycles.
REQ-029 HOLD: out_valid=1, in_ready=0; out_acc and out_ovf SHALL stay stable until out_valid & out_ready at an edge, then the FSM goes to IDLE.
REQ-030 out_valid SHALL NOT depend combinationally on out_ready.
REQ-031 in_ready SHALL be a function of state only.
REQ-032 A beat with first=1 and last=1 SHALL produce a single-product result.
REQ-033 A beat with first=0 after a completed result SHALL add to the retained acc; acc is never cleared implicitly.
REQ-034 in_valid while not ready SHALL be ignored; inputs are not captured.
REQ-035 out_acc and out_ovf SHALL always reflect the current acc/ovf registers; they are qualified only by out_valid.

Reset
REQ-036 While rst=1, SHALL force state=IDLE, acc=0, ovf=0, settle_cnt=0, operand regs=0, out_valid=0, busy=0 and in_ready=0.
REQ-037 in_ready SHALL rise at the first clock edge after rst deasserts.
REQ-038 Reset asserted mid-SETTLE or mid-HOLD SHALL abort immediately; the pending product is discarded.

Structure
REQ-039 SHALL instantiate exactly one sub-module: the team's combinational 32x32 multiplier Mul_32_Hybrid_64_BK1_SA5 (a, b, out[63:0]), driven only from the operand registers.
REQ-040 A shared package mul_acc_pkg SHALL hold the FSM state enum, the default SETTLE_CYCLES and ACC_W, and the product width constant (64).
REQ-041 Timing constraints SHALL declare a SETTLE_CYCLES-cycle multicycle path from the operand registers to the accumulator.

Verification
REQ-042 Reset then one beat a=3, b=5, first=1, last=1 accepted at edge k -> out_valid at edge k+2, out_acc=15, ovf=0.
REQ-043 Beats (2,3,first), (4,5), (6,7,last) with out_ready=1 -> out_acc=68; in_ready low exactly 2 cycles after each accept.
REQ-044 ACC_W=64; beats (FFFFFFFF,FFFFFFFF,first), (FFFFFFFF,FFFFFFFF,last) -> out_acc=FFFFFFFC00000002, out_ovf=1; a next first-beat 1x1 -> acc=1, ovf=0.
REQ-045 out_ready held low for 5 cycles in HOLD -> out_acc stable, in_ready=0, and a beat offered with in_valid=1 is not accepted until the cycle after the handshake.
REQ-046 rst asserted one cycle into SETTLE of beat (9,9,first,last) -> out_valid=0, acc=0 immediately; the next beat (1,2,first,last) -> 2.
REQ-047 1000 random unsigned beats in random first/last groupings with random out_ready stalls -> every result equals the modular reference sum.
